// File: rtl/matdet8_loader.sv
`default_nettype none
// ============================================================================
// Module   : matdet8_loader
// Brief    : Serial row-major element loader feeding the 8x8 determinant
//            block; captures the returned determinant after a settle delay.
// Revision : 1.0 - initial release
// ============================================================================
module matdet8_loader #(
  parameter int DATA_WIDTH    = 8,
  parameter int MATRIX_SIZE   = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic                              s_last,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] mat_out,
  input  logic [DATA_WIDTH-1:0]             det_in,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_WIDTH-1:0]             m_det,
  output logic                              m_err
);

  localparam int c_idx_w      = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam int c_settle_eff = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int c_cnt_w      = (c_settle_eff > 1) ? $clog2(c_settle_eff) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(MATRIX_SIZE - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_settle_eff - 1);

  typedef enum logic [1:0] {
    c_st_load   = 2'd0,
    c_st_settle = 2'd1,
    c_st_hold   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_elem [MATRIX_SIZE];
  logic [c_idx_w-1:0]    r_idx;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_err_pending;
  logic [DATA_WIDTH-1:0] r_det;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_idx_last;

  assign w_accept   = s_valid && (r_state == c_st_load);
  assign w_idx_last = (r_idx == c_last_idx);
  assign m_det      = r_det;
  assign m_err      = r_err;

  generate
    for (genvar gi = 0; gi < MATRIX_SIZE; gi++) begin : g_flat
      assign mat_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_elem[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_load;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    case (r_state)
      c_st_load: begin
        s_ready = 1'b1;
        if (w_accept) begin
          if (w_idx_last) begin
            w_state_nxt = c_st_settle;
          end else if (s_last) begin
            w_state_nxt = c_st_hold;
          end
        end
      end
      c_st_settle: begin
        if (r_cnt == '0) begin
          w_state_nxt = c_st_hold;
        end
      end
      c_st_hold: begin
        m_valid = 1'b1;
        if (m_ready) begin
          w_state_nxt = c_st_load;
        end
      end
      default: begin
        w_state_nxt = c_st_load;
      end
    endcase
  end

  // Datapath: element slots, frame index, settle countdown and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        r_elem[i] <= '0;
      end
      r_idx         <= '0;
      r_cnt         <= '0;
      r_err_pending <= 1'b0;
      r_det         <= '0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        c_st_load: begin
          if (w_accept) begin
            r_elem[r_idx] <= s_data;
            if (w_idx_last) begin
              r_idx         <= '0;
              r_cnt         <= c_cnt_load;
              r_err_pending <= !s_last;
            end else begin
              r_idx <= r_idx + 1'b1;
              // Early last aborts the frame without waiting for the settle time.
              if (s_last) begin
                r_det <= '0;
                r_err <= 1'b1;
              end
            end
          end
        end
        c_st_settle: begin
          if (r_cnt == '0) begin
            r_det <= det_in;
            r_err <= r_err_pending;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        c_st_hold: begin
          if (m_ready) begin
            r_idx <= '0;
          end
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
